alu_decode: RTL

Decode/issue register sitting directly in front of the core's ALU. It accepts one RV32I instruction per handshake, plus its PC and register-file read data. It decodes the instruction into the ALU's 12-bit one-hot operation select and two 32-bit operands, and holds the result in a single valid/ready pipeline register. It also keeps a saturating count of illegal (non-ALU) instructions.

---
 rtl/alu_decode_if.sv | 33 +++
 rtl/alu_decode.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_decode_if.sv
// rtl/alu_decode_if.sv - issue handshake and decoded-operand bundle for alu_decode
interface alu_decode_if #(
    parameter int CNT_W = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [31:0]       in_pc;
    logic [31:0]       in_rs1_data;
    logic [31:0]       in_rs2_data;
    logic              out_valid;
    logic              out_ready;
    logic [11:0]       out_alu_control;
    logic [31:0]       out_alu_src1;
    logic [31:0]       out_alu_src2;
    logic [4:0]        out_rd;
    logic              out_rf_wen;
    logic              out_illegal;
    logic [CNT_W-1:0]  illegal_cnt;

    modport master (
        output flush, in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, out_alu_control, out_alu_src1, out_alu_src2,
               out_rd, out_rf_wen, out_illegal, illegal_cnt
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, out_alu_control, out_alu_src1, out_alu_src2,
               out_rd, out_rf_wen, out_illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - RV32I ALU decode/issue register with saturating illegal counter
module alu_decode #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    alu_decode_if.slave bus
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [11:0] ALU_ADD  = 12'h001;
    localparam logic [11:0] ALU_SUB  = 12'h002;
    localparam logic [11:0] ALU_SLT  = 12'h004;
    localparam logic [11:0] ALU_SLTU = 12'h008;
    localparam logic [11:0] ALU_AND  = 12'h010;
    localparam logic [11:0] ALU_OR   = 12'h040;
    localparam logic [11:0] ALU_XOR  = 12'h080;
    localparam logic [11:0] ALU_SLL  = 12'h100;
    localparam logic [11:0] ALU_SRL  = 12'h200;
    localparam logic [11:0] ALU_SRA  = 12'h400;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [11:0]      dec_ctrl;
    logic [31:0]      dec_src1;
    logic [31:0]      dec_src2;
    logic             dec_legal;

    logic             valid_q;
    logic [11:0]      ctrl_q;
    logic [31:0]      src1_q;
    logic [31:0]      src2_q;
    logic [4:0]       rd_q;
    logic             wen_q;
    logic             ill_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;

    // funct3 encodings shared by OP and OP-IMM for the non-shift arithmetic group
    function automatic logic [11:0] arith_ctrl(input logic [2:0] f3);
        logic [11:0] c;
        case (f3)
            3'b000:  c = ALU_ADD;
            3'b010:  c = ALU_SLT;
            3'b011:  c = ALU_SLTU;
            3'b100:  c = ALU_XOR;
            3'b110:  c = ALU_OR;
            3'b111:  c = ALU_AND;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    // Shifts put the amount on src1 and the value on src2: the ALU shifts src2 by src1[4:0].
    always_comb begin
        dec_ctrl  = 12'h000;
        dec_src1  = 32'd0;
        dec_src2  = 32'd0;
        dec_legal = 1'b0;
        case (bus.in_inst[6:0])
            OPC_OP: begin
                if (bus.in_inst[31:25] == F7_BASE) begin
                    dec_legal = 1'b1;
                    dec_src1  = bus.in_rs1_data;
                    dec_src2  = bus.in_rs2_data;
                    case (bus.in_inst[14:12])
                        3'b001: begin
                            dec_ctrl = ALU_SLL;
                            dec_src1 = {27'd0, bus.in_rs2_data[4:0]};
                            dec_src2 = bus.in_rs1_data;
                        end
                        3'b101: begin
                            dec_ctrl = ALU_SRL;
                            dec_src1 = {27'd0, bus.in_rs2_data[4:0]};
                            dec_src2 = bus.in_rs1_data;
                        end
                        default: dec_ctrl = arith_ctrl(bus.in_inst[14:12]);
                    endcase
                end else if (bus.in_inst[31:25] == F7_ALT && bus.in_inst[14:12] == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = ALU_SUB;
                    dec_src1  = bus.in_rs1_data;
                    dec_src2  = bus.in_rs2_data;
                end else if (bus.in_inst[31:25] == F7_ALT && bus.in_inst[14:12] == 3'b101) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = ALU_SRA;
                    dec_src1  = {27'd0, bus.in_rs2_data[4:0]};
                    dec_src2  = bus.in_rs1_data;
                end
            end
            OPC_OPIMM: begin
                case (bus.in_inst[14:12])
                    3'b001: begin
                        if (bus.in_inst[31:25] == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_ctrl  = ALU_SLL;
                            dec_src1  = {27'd0, bus.in_inst[24:20]};
                            dec_src2  = bus.in_rs1_data;
                        end
                    end
                    3'b101: begin
                        if (bus.in_inst[31:25] == F7_BASE || bus.in_inst[31:25] == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_ctrl  = (bus.in_inst[31:25] == F7_ALT) ? ALU_SRA : ALU_SRL;
                            dec_src1  = {27'd0, bus.in_inst[24:20]};
                            dec_src2  = bus.in_rs1_data;
                        end
                    end
                    default: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = arith_ctrl(bus.in_inst[14:12]);
                        dec_src1  = bus.in_rs1_data;
                        dec_src2  = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
                    end
                endcase
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_ADD;
                dec_src2  = {bus.in_inst[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_ADD;
                dec_src1  = bus.in_pc;
                dec_src2  = {bus.in_inst[31:12], 12'd0};
            end
            default: ;
        endcase
    end

    assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Flush has priority; accept already excludes flush through in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= 12'h000;
            src1_q  <= 32'd0;
            src2_q  <= 32'd0;
            rd_q    <= 5'd0;
            wen_q   <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= dec_ctrl;
            src1_q  <= dec_src1;
            src2_q  <= dec_src2;
            rd_q    <= bus.in_inst[11:7];
            wen_q   <= dec_legal && (bus.in_inst[11:7] != 5'd0);
            ill_q   <= !dec_legal;
            if (!dec_legal && cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid       = valid_q;
    assign bus.out_alu_control = ctrl_q;
    assign bus.out_alu_src1    = src1_q;
    assign bus.out_alu_src2    = src2_q;
    assign bus.out_rd          = rd_q;
    assign bus.out_rf_wen      = wen_q;
    assign bus.out_illegal     = ill_q;
    assign bus.illegal_cnt     = cnt_q;
endmodule
